// File: rtl/drum_mem_unit.sv
// Rotating magnetic-drum main store: serves one read/write request per word slot pass.
// Define DRUM_FAST_EN to bypass the rotational wait (reply two cycles after the request).
module drum_mem_unit #(
    parameter int ADDR_W          = 10,
    parameter int WORD_W          = 31,
    parameter int CYCLES_PER_WORD = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read_from_pu,
    input  logic              mem_write_from_ac,
    input  logic [ADDR_W-1:0] addr_from_sel,
    input  logic [WORD_W-1:0] data_from_ac,
    output logic              mem_reply_to_pu,
    output logic [WORD_W-1:0] data_to_ac,
    output logic              busy_to_pu,
    output logic              mem_err_to_io
);

    localparam int SUB_W = $clog2(CYCLES_PER_WORD);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_WORD - 1);
    localparam logic [SUB_W-1:0] SUB_PRE  = SUB_W'(CYCLES_PER_WORD - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [SUB_W-1:0]    sub_q;
    logic [ADDR_W-1:0]   pos_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                reply_q;
    logic [WORD_W-1:0]   rdata_q;
    logic                err_q;
    logic [WORD_W-1:0]   store [2**ADDR_W];

    logic req_any, accept, err_set, slot_hit, slot_last, fire;

    assign req_any = mem_read_from_pu | mem_write_from_ac;
    assign accept  = (state_q == IDLE) && req_any;
    assign err_set = req_any && ((state_q != IDLE) || (mem_read_from_pu && mem_write_from_ac));

`ifdef DRUM_FAST_EN
    assign slot_hit  = 1'b1;
    assign slot_last = 1'b1;
`else
    // The slot counts only if its first cycle is seen while already waiting.
    assign slot_hit  = (sub_q == '0) && (pos_q == addr_q);
    assign slot_last = (sub_q == SUB_LAST);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = WAIT;
            WAIT:    if (slot_hit)  state_d = ACCESS;
            ACCESS:  if (slot_last) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Access is committed one cycle early so reply and read data appear together
    // on the last cycle of the slot.
`ifdef DRUM_FAST_EN
    assign fire = (state_q == WAIT);
`else
    assign fire = (state_d == ACCESS) && (sub_q == SUB_PRE);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sub_q   <= '0;
            pos_q   <= '0;
            state_q <= IDLE;
            reply_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (sub_q == SUB_LAST) begin
                sub_q <= '0;
                pos_q <= pos_q + 1'b1;
            end else begin
                sub_q <= sub_q + 1'b1;
            end
            state_q <= state_d;
            reply_q <= fire;
            if (fire && !wr_q)
                rdata_q <= store[addr_q];
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Write wins when both request pulses coincide.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr_from_sel;
            wr_q    <= mem_write_from_ac;
            wdata_q <= data_from_ac;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && fire && wr_q)
            store[addr_q] <= wdata_q;
    end

    assign mem_reply_to_pu = reply_q;
    assign data_to_ac      = rdata_q;
    assign busy_to_pu      = (state_q != IDLE);
    assign mem_err_to_io   = err_q;

endmodule

// File: tb/tb_drum_mem_unit.sv
// Self-checking bench for drum_mem_unit (ADDR_W=3, CYCLES_PER_WORD=2, 16-cycle revolution).
module tb_drum_mem_unit;

    localparam int AW  = 3;
    localparam int WW  = 31;
    localparam int CPW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [WW-1:0] wdata = '0;
    logic          reply;
    logic [WW-1:0] rdata;
    logic          busy;
    logic          err;

    drum_mem_unit #(.ADDR_W(AW), .WORD_W(WW), .CYCLES_PER_WORD(CPW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_read_from_pu  (rd),
        .mem_write_from_ac (wr),
        .addr_from_sel     (addr),
        .data_from_ac      (wdata),
        .mem_reply_to_pu   (reply),
        .data_to_ac        (rdata),
        .busy_to_pu        (busy),
        .mem_err_to_io     (err)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first cycle after reset release.
    int cyc = 0;
    always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            cyc;
        logic [WW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [1:0]    op0;
        logic [AW-1:0] a0;
        logic [WW-1:0] d0;
        int            c0;
        int            r0;
        logic [WW-1:0] x0;
        logic [1:0]    op1;
        logic [AW-1:0] a1;
        logic [WW-1:0] d1;
        int            c1;
        int            r1;
        logic [WW-1:0] x1;
        int            len;
        logic          err;
        logic [WW-1:0] fin;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    function automatic vec_t mk(input int op0, input int a0, input int d0, input int c0,
                                input int r0, input int x0, input int op1, input int a1,
                                input int d1, input int c1, input int r1, input int x1,
                                input int len, input int e, input int fin);
        vec_t v;
        v.op0 = 2'(op0); v.a0 = AW'(a0); v.d0 = WW'(d0); v.c0 = c0; v.r0 = r0; v.x0 = WW'(x0);
        v.op1 = 2'(op1); v.a1 = AW'(a1); v.d1 = WW'(d1); v.c1 = c1; v.r1 = r1; v.x1 = WW'(x1);
        v.len = len; v.err = e[0]; v.fin = WW'(fin);
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en && resetn && reply) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_reply at cycle %0d: got reply=1 want 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("reply_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("reply_data", 32'(rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic do_reset();
        rd = 1'b0;
        wr = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
        int n;
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0;
        n = 0;
        while (!reply && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL preload_timeout addr %0d: got no reply want reply within 40 cycles", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input int c, input logic [WW-1:0] d);
        exp_t e;
        e.cyc = c;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // op: 1=read, 2=write, 3=read+write; reply -1 = none expected
`ifdef DRUM_FAST_EN
        vt[0] = mk(1, 3, 0,      1,  3, 'h0ABC, 0, 0, 0, -1, -1, 0,      12, 0, 'h0ABC);
        vt[1] = mk(2, 5, 'h1234, 1,  3, 0,      1, 5, 0, 12, 14, 'h1234, 32, 0, 'h1234);
        vt[2] = mk(1, 2, 0,      4,  6, 'h0222, 0, 0, 0, -1, -1, 0,      26, 0, 'h0222);
        vt[3] = mk(3, 6, 'h0666, 1,  3, 0,      1, 6, 0, 14, 16, 'h0666, 34, 1, 'h0666);
        vt[4] = mk(1, 3, 0,      1,  3, 'h0ABC, 1, 0, 0,  3, -1, 0,      12, 1, 'h0ABC);
        vt[5] = mk(1, 1, 0,      1,  3, 'h0111, 0, 0, 0, -1, -1, 0,       8, 0, 'h0111);
        vt[6] = mk(1, 7, 0,     15, 17, 'h0777, 1, 0, 0, 32, 34, 'h0F0F, 54, 0, 'h0F0F);
`else
        vt[0] = mk(1, 3, 0,      1,  7, 'h0ABC, 0, 0, 0, -1, -1, 0,      12, 0, 'h0ABC);
        vt[1] = mk(2, 5, 'h1234, 1, 11, 0,      1, 5, 0, 12, 27, 'h1234, 32, 0, 'h1234);
        vt[2] = mk(1, 2, 0,      4, 21, 'h0222, 0, 0, 0, -1, -1, 0,      26, 0, 'h0222);
        vt[3] = mk(3, 6, 'h0666, 1, 13, 0,      1, 6, 0, 14, 29, 'h0666, 34, 1, 'h0666);
        vt[4] = mk(1, 3, 0,      1,  7, 'h0ABC, 1, 0, 0,  3, -1, 0,      12, 1, 'h0ABC);
        vt[5] = mk(1, 1, 0,      1,  3, 'h0111, 0, 0, 0, -1, -1, 0,       8, 0, 'h0111);
        vt[6] = mk(1, 7, 0,     15, 31, 'h0777, 1, 0, 0, 32, 49, 'h0F0F, 54, 0, 'h0F0F);
`endif

        do_reset();
        preload(3'd0, 31'h0F0F);
        preload(3'd1, 31'h0111);
        preload(3'd2, 31'h0222);
        preload(3'd3, 31'h0ABC);
        preload(3'd6, 31'h0555);
        preload(3'd7, 31'h0777);

        for (int v = 0; v < NV; v++) begin
            vec_t t;
            t = vt[v];
            do_reset();
            sb.delete();
            mon_en = 1'b1;
            for (int n = 0; n < t.len; n++) begin
                if (n == 0) begin
                    chk("reset_reply", 32'(reply), 0);
                    chk("reset_data", 32'(rdata), 0);
                    chk("reset_busy", 32'(busy), 0);
                    chk("reset_err", 32'(err), 0);
                end
                if (n == t.c0 + 1) chk("busy_after_req", 32'(busy), 1);
                if (t.r0 >= 0 && n == t.r0 + 1) chk("busy_after_reply", 32'(busy), 0);
                rd    = (n == t.c0 && t.op0[0]) || (n == t.c1 && t.op1[0]);
                wr    = (n == t.c0 && t.op0[1]) || (n == t.c1 && t.op1[1]);
                addr  = (n == t.c1) ? t.a1 : t.a0;
                wdata = (n == t.c1) ? t.d1 : t.d0;
                if (n == t.c0 && t.r0 >= 0) push_exp(t.r0, t.x0);
                if (n == t.c1 && t.r1 >= 0) push_exp(t.r1, t.x1);
                @(posedge clk); #1;
                rd = 1'b0;
                wr = 1'b0;
            end
            chk("pending_replies", 32'(sb.size()), 0);
            chk("final_err", 32'(err), 32'(t.err));
            chk("final_data", 32'(rdata), 32'(t.fin));
            chk("final_busy", 32'(busy), 0);
            mon_en = 1'b0;
        end

        // Reset in the middle of a pending read: no reply, every output back to 0.
        do_reset();
        sb.delete();
        mon_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n == 2) chk("abort_busy", 32'(busy), 1);
            if (n == 4) chk("abort_err_set", 32'(err), 1);
            rd   = (n == 1) || (n == 3);
            addr = (n == 1) ? 3'd3 : 3'd0;
`ifdef DRUM_FAST_EN
            if (n == 1) push_exp(3, 31'h0ABC);
`endif
            @(posedge clk); #1;
            rd = 1'b0;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort_reply", 32'(reply), 0);
        chk("abort_data", 32'(rdata), 0);
        chk("abort_busy_clr", 32'(busy), 0);
        chk("abort_err_clr", 32'(err), 0);
        resetn = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_pending", 32'(sb.size()), 0);
        chk("abort_idle", 32'(busy), 0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
